// File: rtl/skew_buffer3.sv
// Ping-pong input skew buffer: accepts ARRAY_SIZE x ARRAY_SIZE tiles row by row and
// drains committed tiles onto ARRAY_SIZE diagonally skewed lanes. Optional SKEW_BUFFER3_TRANSPOSE_EN.
module skew_buffer3 #(
    parameter int DATA_WIDTH = 8,
    parameter int ARRAY_SIZE = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic signed [DATA_WIDTH-1:0] data_in [ARRAY_SIZE],
`ifdef SKEW_BUFFER3_TRANSPOSE_EN
    input  logic                         transpose,
`endif
    output logic signed [DATA_WIDTH-1:0] data_out [ARRAY_SIZE],
    output logic [ARRAY_SIZE-1:0]        lane_valid,
    output logic                         out_first,
    output logic                         out_last,
    output logic                         busy
);

    localparam int unsigned STEP_W = $clog2(2*ARRAY_SIZE-1);
    localparam int unsigned IDX_W  = $clog2(ARRAY_SIZE);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(2*ARRAY_SIZE-2);
    localparam logic [IDX_W-1:0]  LAST_ROW  = IDX_W'(ARRAY_SIZE-1);

    typedef enum logic {IDLE, DRAIN} state_t;

    logic signed [DATA_WIDTH-1:0] mem_q [2][ARRAY_SIZE][ARRAY_SIZE];
    logic signed [DATA_WIDTH-1:0] mem_d [2][ARRAY_SIZE][ARRAY_SIZE];
    logic                         wbank_q, wbank_d;
    logic                         rbank_q, rbank_d;
    logic [IDX_W-1:0]             wrow_q, wrow_d;
    logic [1:0]                   full_q, full_d;
    logic [STEP_W-1:0]            step_q, step_d;
    state_t                       state_q, state_d;
    logic signed [DATA_WIDTH-1:0] data_out_q [ARRAY_SIZE];
    logic signed [DATA_WIDTH-1:0] data_out_d [ARRAY_SIZE];
    logic [ARRAY_SIZE-1:0]        lane_valid_q, lane_valid_d;
    logic                         first_q, first_d;
    logic                         last_q, last_d;
    logic                         fill_now;
    logic                         next_ready;
`ifdef SKEW_BUFFER3_TRANSPOSE_EN
    logic [1:0]                   tr_q, tr_d;
`endif

    assign wr_ready   = ~full_q[wbank_q];
    assign busy       = (state_q == DRAIN);
    assign data_out   = data_out_q;
    assign lane_valid = lane_valid_q;
    assign out_first  = first_q;
    assign out_last   = last_q;

    always_comb begin
        mem_d        = mem_q;
        wbank_d      = wbank_q;
        wrow_d       = wrow_q;
        full_d       = full_q;
        rbank_d      = rbank_q;
        step_d       = step_q;
        state_d      = state_q;
        data_out_d   = data_out_q;
        lane_valid_d = lane_valid_q;
        first_d      = first_q;
        last_d       = last_q;
        fill_now     = 1'b0;
        next_ready   = 1'b0;
`ifdef SKEW_BUFFER3_TRANSPOSE_EN
        tr_d         = tr_q;
`endif

        // Write side runs regardless of enable; only the drain is gated.
        if (wr_valid && wr_ready) begin
            for (int unsigned c = 0; c < ARRAY_SIZE; c++) begin
                mem_d[wbank_q][wrow_q][IDX_W'(c)] = data_in[IDX_W'(c)];
            end
`ifdef SKEW_BUFFER3_TRANSPOSE_EN
            if (wrow_q == '0) begin
                tr_d[wbank_q] = transpose;
            end
`endif
            if (wrow_q == LAST_ROW) begin
                fill_now        = 1'b1;
                full_d[wbank_q] = 1'b1;
                wbank_d         = ~wbank_q;
                wrow_d          = '0;
            end else begin
                wrow_d = wrow_q + 1'b1;
            end
        end

        if (enable) begin
            case (state_q)
                IDLE: begin
                    data_out_d   = '{default: '0};
                    lane_valid_d = '0;
                    first_d      = 1'b0;
                    last_d       = 1'b0;
                    if (full_q[rbank_q]) begin
                        state_d = DRAIN;
                        step_d  = '0;
                    end
                end
                DRAIN: begin
                    for (int unsigned k = 0; k < ARRAY_SIZE; k++) begin
                        int i;
                        i = int'(step_q) - int'(k);
                        if (i >= 0 && i < ARRAY_SIZE) begin
                            lane_valid_d[IDX_W'(k)] = 1'b1;
`ifdef SKEW_BUFFER3_TRANSPOSE_EN
                            if (tr_q[rbank_q]) begin
                                data_out_d[IDX_W'(k)] = mem_q[rbank_q][IDX_W'(i)][IDX_W'(k)];
                            end else begin
                                data_out_d[IDX_W'(k)] = mem_q[rbank_q][IDX_W'(k)][IDX_W'(i)];
                            end
`else
                            data_out_d[IDX_W'(k)] = mem_q[rbank_q][IDX_W'(k)][IDX_W'(i)];
`endif
                        end else begin
                            lane_valid_d[IDX_W'(k)] = 1'b0;
                            data_out_d[IDX_W'(k)]   = '0;
                        end
                    end
                    first_d = (step_q == '0);
                    last_d  = (step_q == LAST_STEP);
                    if (step_q == LAST_STEP) begin
                        // A tile committing into the other bank on this edge still chains without a bubble.
                        next_ready       = full_q[~rbank_q] | (fill_now & (wbank_q != rbank_q));
                        full_d[rbank_q]  = 1'b0;
                        rbank_d          = ~rbank_q;
                        step_d           = '0;
                        state_d          = next_ready ? DRAIN : IDLE;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbank_q      <= 1'b0;
            rbank_q      <= 1'b0;
            wrow_q       <= '0;
            full_q       <= '0;
            step_q       <= '0;
            state_q      <= IDLE;
            data_out_q   <= '{default: '0};
            lane_valid_q <= '0;
            first_q      <= 1'b0;
            last_q       <= 1'b0;
`ifdef SKEW_BUFFER3_TRANSPOSE_EN
            tr_q         <= '0;
`endif
        end else begin
            wbank_q      <= wbank_d;
            rbank_q      <= rbank_d;
            wrow_q       <= wrow_d;
            full_q       <= full_d;
            step_q       <= step_d;
            state_q      <= state_d;
            data_out_q   <= data_out_d;
            lane_valid_q <= lane_valid_d;
            first_q      <= first_d;
            last_q       <= last_d;
`ifdef SKEW_BUFFER3_TRANSPOSE_EN
            tr_q         <= tr_d;
`endif
        end
    end

    // Tile storage carries no reset; the full flags decide what is meaningful.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule
